// File: rtl/cart_mapper_pkg.sv
// -----------------------------------------------------------------------------
// cart_mapper_pkg
// Shared types and helpers for the cartridge mapper:
//   - mapper_e        : decoded memory bank controller family
//   - latch_state_e   : RTC latch sequence state
//   - rtc_time_t      : RTC counter/register bundle (live and latched copies)
//   - RTC_REG_*       : values written to 4000-5FFF that select an RTC register
//   - decode_mapper() : header byte 0x147 -> mapper_e
//   - rom_bank_mask() : header byte 0x148 -> ROM bank mask
//   - ram_bank_mask() : header byte 0x149 -> RAM bank mask
// -----------------------------------------------------------------------------
package cart_mapper_pkg;

  typedef enum logic [2:0] {
    MAP_NONE = 3'd0,
    MAP_MBC1 = 3'd1,
    MAP_MBC2 = 3'd2,
    MAP_MBC3 = 3'd3,
    MAP_MBC5 = 3'd4
  } mapper_e;

  typedef enum logic {
    LATCH_IDLE  = 1'b0,
    LATCH_ARMED = 1'b1
  } latch_state_e;

  typedef struct packed {
    logic       carry;
    logic       halt;
    logic [8:0] day;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } rtc_time_t;

  localparam logic [7:0] RTC_REG_S  = 8'h08;
  localparam logic [7:0] RTC_REG_M  = 8'h09;
  localparam logic [7:0] RTC_REG_H  = 8'h0A;
  localparam logic [7:0] RTC_REG_DL = 8'h0B;
  localparam logic [7:0] RTC_REG_DH = 8'h0C;

  function automatic mapper_e decode_mapper(input logic [7:0] t);
    mapper_e m;
    m = MAP_NONE;
    if (t >= 8'h01 && t <= 8'h03) m = MAP_MBC1;
    else if (t >= 8'h05 && t <= 8'h06) m = MAP_MBC2;
    else if (t >= 8'h0F && t <= 8'h13) m = MAP_MBC3;
    else if (t >= 8'h19 && t <= 8'h1E) m = MAP_MBC5;
    return m;
  endfunction

  // Size code n means 2^(n+1) banks of 16 KB; the 0x52-0x54 oddballs all
  // mirror within 128 banks. Unknown large codes leave the bank unmasked.
  function automatic logic [15:0] rom_bank_mask(input logic [7:0] n);
    logic [15:0] m;
    if (n >= 8'h52 && n <= 8'h54) m = 16'd127;
    else if (n <= 8'd8)           m = (16'd2 << n) - 16'd1;
    else                          m = 16'hFFFF;
    return m;
  endfunction

  function automatic logic [3:0] ram_bank_mask(input logic [7:0] n);
    logic [3:0] m;
    case (n)
      8'd3:    m = 4'd3;
      8'd4:    m = 4'd15;
      8'd5:    m = 4'd7;
      default: m = 4'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cart_rtc.sv
// -----------------------------------------------------------------------------
// cart_rtc
// MBC3 real-time clock: live counters, latched copy, latch sequence FSM and
// register select. Only built when MBC_RTC_EN is defined.
// Ports:
//   clk_sys, reset   : clock, synchronous active-high reset
//   sel_wr_i         : qualified write to 4000-5FFF (register select)
//   latch_wr_i       : qualified write to 6000-7FFF (latch sequence)
//   reg_wr_i         : qualified write to A000-BFFF while RTC is mapped
//   data_i           : CPU write data
//   sec_tick_i       : one-cycle 1 Hz strobe
//   rtc_sel_o        : A000-BFFF currently maps to an RTC register
//   rtc_do_o         : selected latched register, unused bits read as 1
//   latch_state_o    : latch FSM state (debug)
// -----------------------------------------------------------------------------
module cart_rtc
  import cart_mapper_pkg::*;
(
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         sel_wr_i,
  input  logic         latch_wr_i,
  input  logic         reg_wr_i,
  input  logic [7:0]   data_i,
  input  logic         sec_tick_i,
  output logic         rtc_sel_o,
  output logic [7:0]   rtc_do_o,
  output latch_state_e latch_state_o
);

  latch_state_e state_q, state_d;
  rtc_time_t    live_q, live_d;
  rtc_time_t    latch_q, latch_d;
  logic         sel_q, sel_d;
  logic [7:0]   reg_q, reg_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= LATCH_IDLE;
      live_q  <= '0;
      latch_q <= '0;
      sel_q   <= 1'b0;
      reg_q   <= RTC_REG_S;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      latch_q <= latch_d;
      sel_q   <= sel_d;
      reg_q   <= reg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    latch_d = latch_q;
    sel_d   = sel_q;
    reg_d   = reg_q;

    // 00-07 hand A000-BFFF back to RAM; 08-0C select an RTC register.
    if (sel_wr_i) begin
      if (data_i <= 8'h07) begin
        sel_d = 1'b0;
      end else if (data_i >= RTC_REG_S && data_i <= RTC_REG_DH) begin
        sel_d = 1'b1;
        reg_d = data_i;
      end
    end

    // A CPU write updates both copies and swallows a coincident tick.
    if (reg_wr_i) begin
      case (reg_q)
        RTC_REG_S:  begin live_d.s = data_i[5:0]; latch_d.s = data_i[5:0]; end
        RTC_REG_M:  begin live_d.m = data_i[5:0]; latch_d.m = data_i[5:0]; end
        RTC_REG_H:  begin live_d.h = data_i[4:0]; latch_d.h = data_i[4:0]; end
        RTC_REG_DL: begin live_d.day[7:0] = data_i; latch_d.day[7:0] = data_i; end
        RTC_REG_DH: begin
          live_d.day[8]  = data_i[0];
          live_d.halt    = data_i[6];
          live_d.carry   = data_i[7];
          latch_d.day[8] = data_i[0];
          latch_d.halt   = data_i[6];
          latch_d.carry  = data_i[7];
        end
        default: ;
      endcase
    end else if (sec_tick_i && !live_q.halt) begin
      // Out-of-range values keep counting to all-ones and wrap silently.
      if (live_q.s == 6'd59 || live_q.s == 6'd63) live_d.s = 6'd0;
      else                                         live_d.s = live_q.s + 6'd1;
      if (live_q.s == 6'd59) begin
        if (live_q.m == 6'd59 || live_q.m == 6'd63) live_d.m = 6'd0;
        else                                         live_d.m = live_q.m + 6'd1;
        if (live_q.m == 6'd59) begin
          if (live_q.h == 5'd23 || live_q.h == 5'd31) live_d.h = 5'd0;
          else                                         live_d.h = live_q.h + 5'd1;
          if (live_q.h == 5'd23) begin
            live_d.day = live_q.day + 9'd1;
            if (live_q.day == 9'd511) live_d.carry = 1'b1;
          end
        end
      end
    end

    // Latch needs 0x00 then 0x01 back to back; anything else disarms.
    if (latch_wr_i) begin
      case (state_q)
        LATCH_IDLE: begin
          if (data_i == 8'h00) state_d = LATCH_ARMED;
        end
        LATCH_ARMED: begin
          state_d = LATCH_IDLE;
          if (data_i == 8'h01) latch_d = live_q;
        end
        default: state_d = LATCH_IDLE;
      endcase
    end
  end

  always_comb begin
    rtc_do_o = 8'hFF;
    case (reg_q)
      RTC_REG_S:  rtc_do_o = {2'b11, latch_q.s};
      RTC_REG_M:  rtc_do_o = {2'b11, latch_q.m};
      RTC_REG_H:  rtc_do_o = {3'b111, latch_q.h};
      RTC_REG_DL: rtc_do_o = latch_q.day[7:0];
      RTC_REG_DH: rtc_do_o = {latch_q.carry, latch_q.halt, 5'b11111, latch_q.day[8]};
      default:    rtc_do_o = 8'hFF;
    endcase
  end

  assign rtc_sel_o     = sel_q;
  assign latch_state_o = state_q;

endmodule

// File: rtl/cart_mapper.sv
// -----------------------------------------------------------------------------
// cart_mapper
// Game Boy cartridge memory bank controller (NONE/MBC1/MBC2/MBC3/MBC5).
// Build option: define MBC_RTC_EN to include the MBC3 real-time clock.
// Ports:
//   clk_sys, reset        : clock, synchronous active-high reset
//   ce                    : CPU bus clock enable, qualifies cart_wr
//   cart_addr/cart_wr/cart_di : CPU cartridge bus
//   mbc_type/rom_size/ram_size: header bytes 0x147/0x148/0x149
//   sec_tick              : 1 Hz strobe for the RTC
//   rom_page              : 8 KB ROM page {bank, cart_addr[13]}
//   ram_bank              : cart RAM bank
//   ram_en                : cart RAM / RTC access enabled
//   rtc_sel               : A000-BFFF maps to an RTC register
//   rtc_do                : selected latched RTC register
//   dbg_rtc_armed         : RTC latch FSM is in the ARMED state (debug)
// Outputs are combinational from registers and the current address only.
// -----------------------------------------------------------------------------
module cart_mapper
  import cart_mapper_pkg::*;
#(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [15:0]              cart_addr,
  input  logic                     cart_wr,
  input  logic [7:0]               cart_di,
  input  logic [7:0]               mbc_type,
  input  logic [7:0]               rom_size,
  input  logic [7:0]               ram_size,
  input  logic                     sec_tick,
  output logic [ROM_BANK_BITS:0]   rom_page,
  output logic [RAM_BANK_BITS-1:0] ram_bank,
  output logic                     ram_en,
  output logic                     rtc_sel,
  output logic [7:0]               rtc_do,
  output logic                     dbg_rtc_armed
);

  localparam int BW = ROM_BANK_BITS;
  localparam int RB = RAM_BANK_BITS;
  localparam int PW = ROM_BANK_BITS + 1;

  mapper_e       mapper;
  logic          wr_en;
  logic [BW-1:0] bank_q, bank_d;
  logic [1:0]    upper_q, upper_d;
  logic          mode_q, mode_d;
  logic          ram_en_q, ram_en_d;
  logic [RB-1:0] ram_bank_q, ram_bank_d;
  logic [8:0]    bank9;
  logic [4:0]    fix5;
  logic [3:0]    fix4;
  logic [6:0]    fix7;
  logic          ram_en_val;

  assign mapper     = decode_mapper(mbc_type);
  assign wr_en      = ce & cart_wr;
  assign bank9      = 9'(bank_q);
  // MBC1/2/3 cannot select bank 0 through the bank register.
  assign fix5       = (cart_di[4:0] == 5'd0) ? 5'd1 : cart_di[4:0];
  assign fix4       = (cart_di[3:0] == 4'd0) ? 4'd1 : cart_di[3:0];
  assign fix7       = (cart_di[6:0] == 7'd0) ? 7'd1 : cart_di[6:0];
  assign ram_en_val = (cart_di[3:0] == 4'hA);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bank_q     <= BW'(1);
      upper_q    <= 2'd0;
      mode_q     <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_bank_q <= '0;
    end else begin
      bank_q     <= bank_d;
      upper_q    <= upper_d;
      mode_q     <= mode_d;
      ram_en_q   <= ram_en_d;
      ram_bank_q <= ram_bank_d;
    end
  end

  always_comb begin
    bank_d     = bank_q;
    upper_d    = upper_q;
    mode_d     = mode_q;
    ram_en_d   = ram_en_q;
    ram_bank_d = ram_bank_q;
    if (wr_en && !cart_addr[15]) begin
      unique case (mapper)
        MAP_MBC1: begin
          case (cart_addr[14:13])
            2'b00: ram_en_d = ram_en_val;
            2'b01: bank_d   = BW'(fix5);
            2'b10: upper_d  = cart_di[1:0];
            2'b11: mode_d   = cart_di[0];
            default: ;
          endcase
        end
        MAP_MBC2: begin
          // addr[8] picks between the RAM enable and the bank register.
          if (!cart_addr[14]) begin
            if (cart_addr[8]) bank_d   = BW'(fix4);
            else              ram_en_d = ram_en_val;
          end
        end
        MAP_MBC3: begin
          case (cart_addr[14:13])
            2'b00: ram_en_d = ram_en_val;
            2'b01: bank_d   = BW'(fix7);
            2'b10: if (cart_di <= 8'h07) ram_bank_d = RB'(cart_di[2:0]);
            default: ;
          endcase
        end
        MAP_MBC5: begin
          case (cart_addr[14:13])
            2'b00: ram_en_d = ram_en_val;
            2'b01: begin
              if (!cart_addr[12]) bank_d = BW'({bank9[8], cart_di});
              else                bank_d = BW'({cart_di[0], bank9[7:0]});
            end
            2'b10: ram_bank_d = RB'(cart_di[3:0]);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Effective ROM bank for the current address, before size masking.
  // MBC1 applies the upper bits to 4000-7FFF in both modes; mode 1 also
  // applies them to 0000-3FFF and to the RAM bank.
  logic [BW-1:0] bank_eff;
  logic [RB-1:0] ram_src;

  always_comb begin
    bank_eff = '0;
    ram_src  = '0;
    unique case (mapper)
      MAP_MBC1: begin
        if (cart_addr[14]) bank_eff = BW'({upper_q, bank9[4:0]});
        else if (mode_q)   bank_eff = BW'({upper_q, 5'd0});
        if (mode_q) ram_src = RB'(upper_q);
      end
      MAP_MBC2: begin
        if (cart_addr[14]) bank_eff = bank_q;
      end
      MAP_MBC3, MAP_MBC5: begin
        if (cart_addr[14]) bank_eff = bank_q;
        ram_src = ram_bank_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    rom_page = PW'(cart_addr[14:13]);
    if (mapper != MAP_NONE) begin
      rom_page = {bank_eff & BW'(rom_bank_mask(rom_size)), cart_addr[13]};
    end
  end

  assign ram_bank = ram_src & RB'(ram_bank_mask(ram_size));
  assign ram_en   = ram_en_q;

`ifdef MBC_RTC_EN
  latch_state_e rtc_state;
  logic         rtc_sel_w;
  logic         is_mbc3_wr;

  assign is_mbc3_wr = wr_en && (mapper == MAP_MBC3);

  cart_rtc u_rtc (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .sel_wr_i      (is_mbc3_wr && cart_addr[15:13] == 3'b010),
    .latch_wr_i    (is_mbc3_wr && cart_addr[15:13] == 3'b011),
    .reg_wr_i      (is_mbc3_wr && cart_addr[15:13] == 3'b101 && ram_en_q && rtc_sel_w),
    .data_i        (cart_di),
    .sec_tick_i    (sec_tick),
    .rtc_sel_o     (rtc_sel_w),
    .rtc_do_o      (rtc_do),
    .latch_state_o (rtc_state)
  );

  assign rtc_sel       = rtc_sel_w;
  assign dbg_rtc_armed = (rtc_state == LATCH_ARMED);
`else
  logic unused_rtc;
  assign unused_rtc    = &{1'b0, sec_tick};
  assign rtc_sel       = 1'b0;
  assign rtc_do        = 8'hFF;
  assign dbg_rtc_armed = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, cart_addr[11:9], cart_addr[7:0]};

endmodule

// File: tb/tb_cart_mapper.sv
module tb_cart_mapper;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] cart_addr = 16'h0000;
  logic        cart_wr = 1'b0;
  logic [7:0]  cart_di = 8'h00;
  logic [7:0]  mbc_type = 8'h01;
  logic [7:0]  rom_size = 8'h04;
  logic [7:0]  ram_size = 8'h03;
  logic        sec_tick = 1'b0;
  logic [9:0]  rom_page;
  logic [3:0]  ram_bank;
  logic        ram_en;
  logic        rtc_sel;
  logic [7:0]  rtc_do;
  logic        dbg_rtc_armed;

  int checks = 0;
  int errors = 0;

  cart_mapper dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ce            (ce),
    .cart_addr     (cart_addr),
    .cart_wr       (cart_wr),
    .cart_di       (cart_di),
    .mbc_type      (mbc_type),
    .rom_size      (rom_size),
    .ram_size      (ram_size),
    .sec_tick      (sec_tick),
    .rom_page      (rom_page),
    .ram_bank      (ram_bank),
    .ram_en        (ram_en),
    .rtc_sel       (rtc_sel),
    .rtc_do        (rtc_do),
    .dbg_rtc_armed (dbg_rtc_armed)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  task automatic apply_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // drivers
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic ce_v, input logic tick_v);
    @(negedge clk_sys);
    cart_addr = a;
    cart_di   = d;
    cart_wr   = 1'b1;
    ce        = ce_v;
    sec_tick  = tick_v;
    @(negedge clk_sys);
    cart_wr   = 1'b0;
    ce        = 1'b0;
    sec_tick  = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    do_write(a, d, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    sec_tick = 1'b1;
    @(negedge clk_sys);
    sec_tick = 1'b0;
  endtask

  task automatic set_addr(input logic [15:0] a);
    cart_addr = a;
    #1;
  endtask

  task automatic set_cart(input logic [7:0] t, input logic [7:0] rs, input logic [7:0] ms);
    mbc_type = t;
    rom_size = rs;
    ram_size = ms;
    apply_reset();
  endtask

  // tests
  task automatic test_reset();
    mbc_type = 8'h01; rom_size = 8'h04; ram_size = 8'h03;
    // Reset held while a write and tick are offered: reset must win.
    @(negedge clk_sys);
    reset = 1'b1; ce = 1'b1; cart_wr = 1'b1; cart_addr = 16'h2000; cart_di = 8'h1F; sec_tick = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0; ce = 1'b0; cart_wr = 1'b0; sec_tick = 1'b0;
    set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL reset_rom_page got %0d want 2", rom_page); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
    checks++; if (ram_bank !== 4'd0) begin errors++; $display("FAIL reset_ram_bank got %0d want 0", ram_bank); end
    checks++; if (rtc_sel !== 1'b0) begin errors++; $display("FAIL reset_rtc_sel got %b want 0", rtc_sel); end
    checks++; if (dbg_rtc_armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %b want 0", dbg_rtc_armed); end
    set_addr(16'h0000);
    checks++; if (rom_page !== 10'd0) begin errors++; $display("FAIL reset_page_lo got %0d want 0", rom_page); end
  endtask

  task automatic test_mbc1();
    set_cart(8'h01, 8'h04, 8'h03);
    wr(16'h2000, 8'h00); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL mbc1_zero_bank got %0d want 2", rom_page); end
    wr(16'h2000, 8'h21); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL mbc1_mask_21 got %0d want 2", rom_page); end
    wr(16'h2000, 8'h1F); set_addr(16'h6000);
    checks++; if (rom_page !== 10'd63) begin errors++; $display("FAIL mbc1_bank31 got %0d want 63", rom_page); end
    wr(16'h0000, 8'h0A);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL mbc1_ram_en got %b want 1", ram_en); end
    // 128-bank cart: upper bits 2 -> bank 68 in 4000-7FFF.
    rom_size = 8'h06;
    wr(16'h2000, 8'h04); wr(16'h4000, 8'h02); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd136) begin errors++; $display("FAIL mbc1_upper got %0d want 136", rom_page); end
    set_addr(16'h0000);
    checks++; if (rom_page !== 10'd0) begin errors++; $display("FAIL mbc1_mode0_lo got %0d want 0", rom_page); end
    checks++; if (ram_bank !== 4'd0) begin errors++; $display("FAIL mbc1_mode0_ram got %0d want 0", ram_bank); end
    wr(16'h6000, 8'h01); set_addr(16'h0000);
    checks++; if (rom_page !== 10'd128) begin errors++; $display("FAIL mbc1_mode1_lo got %0d want 128", rom_page); end
    checks++; if (ram_bank !== 4'd2) begin errors++; $display("FAIL mbc1_mode1_ram got %0d want 2", ram_bank); end
    rom_size = 8'h04; ram_size = 8'h02; set_addr(16'h4000);
    checks++; if (rom_page !== 10'd8) begin errors++; $display("FAIL mbc1_mirror got %0d want 8", rom_page); end
    checks++; if (ram_bank !== 4'd0) begin errors++; $display("FAIL mbc1_ram_mask got %0d want 0", ram_bank); end
    // Write with ce low must be ignored.
    do_write(16'h2000, 8'h07, 1'b0, 1'b0); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd8) begin errors++; $display("FAIL mbc1_ce_gate got %0d want 8", rom_page); end
  endtask

  task automatic test_mbc2();
    set_cart(8'h05, 8'h03, 8'h00);
    wr(16'h0100, 8'h0A); set_addr(16'h4000);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL mbc2_ram_en_keep got %b want 0", ram_en); end
    checks++; if (rom_page !== 10'd20) begin errors++; $display("FAIL mbc2_bank10 got %0d want 20", rom_page); end
    wr(16'h0000, 8'h0A);
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL mbc2_ram_en got %b want 1", ram_en); end
    wr(16'h0100, 8'h00); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL mbc2_zero_bank got %0d want 2", rom_page); end
    checks++; if (ram_bank !== 4'd0) begin errors++; $display("FAIL mbc2_ram_bank got %0d want 0", ram_bank); end
  endtask

  task automatic test_mbc3();
    set_cart(8'h13, 8'h06, 8'h03);
    wr(16'h2000, 8'h00); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL mbc3_zero_bank got %0d want 2", rom_page); end
    wr(16'h2000, 8'h85); set_addr(16'h6000);
    checks++; if (rom_page !== 10'd11) begin errors++; $display("FAIL mbc3_bank5 got %0d want 11", rom_page); end
    wr(16'h4000, 8'h03);
    checks++; if (ram_bank !== 4'd3) begin errors++; $display("FAIL mbc3_ram_bank got %0d want 3", ram_bank); end
    wr(16'h4000, 8'h0A);
    checks++; if (ram_bank !== 4'd3) begin errors++; $display("FAIL mbc3_rtc_sel_keep_bank got %0d want 3", ram_bank); end
`ifdef MBC_RTC_EN
    checks++; if (rtc_sel !== 1'b1) begin errors++; $display("FAIL mbc3_rtc_sel got %b want 1", rtc_sel); end
`else
    checks++; if (rtc_sel !== 1'b0) begin errors++; $display("FAIL mbc3_no_rtc_sel got %b want 0", rtc_sel); end
    checks++; if (rtc_do !== 8'hFF) begin errors++; $display("FAIL mbc3_no_rtc_do got %h want ff", rtc_do); end
`endif
    wr(16'h4000, 8'h02);
    checks++; if (rtc_sel !== 1'b0) begin errors++; $display("FAIL mbc3_ram_sel got %b want 0", rtc_sel); end
    checks++; if (ram_bank !== 4'd2) begin errors++; $display("FAIL mbc3_ram_bank2 got %0d want 2", ram_bank); end
  endtask

  task automatic test_mbc5();
    set_cart(8'h19, 8'h08, 8'h04);
    wr(16'h2000, 8'hFF); wr(16'h3000, 8'h01); set_addr(16'h6000);
    checks++; if (rom_page !== 10'd1023) begin errors++; $display("FAIL mbc5_bank511 got %0d want 1023", rom_page); end
    rom_size = 8'h52; set_addr(16'h4000);
    checks++; if (rom_page !== 10'd254) begin errors++; $display("FAIL mbc5_mask52 got %0d want 254", rom_page); end
    rom_size = 8'h08;
    wr(16'h2000, 8'h00); wr(16'h3000, 8'h00); set_addr(16'h4000);
    checks++; if (rom_page !== 10'd0) begin errors++; $display("FAIL mbc5_bank0 got %0d want 0", rom_page); end
    wr(16'h4000, 8'h0B);
    checks++; if (ram_bank !== 4'd11) begin errors++; $display("FAIL mbc5_ram_bank got %0d want 11", ram_bank); end
    ram_size = 8'h03; #1;
    checks++; if (ram_bank !== 4'd3) begin errors++; $display("FAIL mbc5_ram_mirror got %0d want 3", ram_bank); end
  endtask

  task automatic test_none();
    set_cart(8'h00, 8'h00, 8'h00);
    wr(16'h2000, 8'h05); set_addr(16'h6000);
    checks++; if (rom_page !== 10'd3) begin errors++; $display("FAIL none_6000 got %0d want 3", rom_page); end
    set_addr(16'h2000);
    checks++; if (rom_page !== 10'd1) begin errors++; $display("FAIL none_2000 got %0d want 1", rom_page); end
  endtask

`ifdef MBC_RTC_EN
  task automatic test_rtc_rollover();
    set_cart(8'h10, 8'h06, 8'h03);
    wr(16'h0000, 8'h0A);
    wr(16'h4000, 8'h08); wr(16'hA000, 8'd59);
    checks++; if (rtc_do !== 8'hFB) begin errors++; $display("FAIL rtc_write_s got %h want fb", rtc_do); end
    wr(16'h4000, 8'h09); wr(16'hA000, 8'd59);
    wr(16'h4000, 8'h0A); wr(16'hA000, 8'd23);
    wr(16'h4000, 8'h0B); wr(16'hA000, 8'hFF);
    wr(16'h4000, 8'h0C); wr(16'hA000, 8'h01);
    checks++; if (rtc_do !== 8'h3F) begin errors++; $display("FAIL rtc_write_dh got %h want 3f", rtc_do); end
    tick();
    wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
    // Register value 0x80 with unused bits forced high reads 0xBE.
    checks++; if (rtc_do !== 8'hBE) begin errors++; $display("FAIL rtc_roll_dh got %h want be", rtc_do); end
    wr(16'h4000, 8'h0B);
    checks++; if (rtc_do !== 8'h00) begin errors++; $display("FAIL rtc_roll_dl got %h want 00", rtc_do); end
    wr(16'h4000, 8'h0A);
    checks++; if (rtc_do !== 8'hE0) begin errors++; $display("FAIL rtc_roll_h got %h want e0", rtc_do); end
    wr(16'h4000, 8'h09);
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rtc_roll_m got %h want c0", rtc_do); end
    wr(16'h4000, 8'h08);
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rtc_roll_s got %h want c0", rtc_do); end
  endtask

  task automatic test_rtc_latch_seq();
    tick();
    wr(16'h6000, 8'h00);
    checks++; if (dbg_rtc_armed !== 1'b1) begin errors++; $display("FAIL rtc_armed got %b want 1", dbg_rtc_armed); end
    wr(16'h6000, 8'h02); wr(16'h6000, 8'h01);
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rtc_no_latch got %h want c0", rtc_do); end
    wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
    checks++; if (rtc_do !== 8'hC1) begin errors++; $display("FAIL rtc_latch got %h want c1", rtc_do); end
    do_write(16'hA000, 8'd10, 1'b1, 1'b1);
    wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
    checks++; if (rtc_do !== 8'hCA) begin errors++; $display("FAIL rtc_write_wins got %h want ca", rtc_do); end
    // Out-of-range seconds: 62 -> 63 -> 0 with no carry into minutes.
    wr(16'h4000, 8'h09); wr(16'hA000, 8'd5);
    wr(16'h4000, 8'h08); wr(16'hA000, 8'd62);
    tick(); tick();
    wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rtc_oor_s got %h want c0", rtc_do); end
    wr(16'h4000, 8'h09);
    checks++; if (rtc_do !== 8'hC5) begin errors++; $display("FAIL rtc_oor_m got %h want c5", rtc_do); end
    // Halt freezes counting.
    wr(16'h4000, 8'h0C); wr(16'hA000, 8'h40);
    checks++; if (rtc_do !== 8'h7E) begin errors++; $display("FAIL rtc_halt_dh got %h want 7e", rtc_do); end
    wr(16'h4000, 8'h08);
    tick();
    wr(16'h6000, 8'h00); wr(16'h6000, 8'h01);
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rtc_halt_s got %h want c0", rtc_do); end
  endtask
`endif

  task automatic test_reset_mid();
    set_cart(8'h10, 8'h06, 8'h03);
    wr(16'h2000, 8'h05); wr(16'h0000, 8'h0A); wr(16'h6000, 8'h00);
    apply_reset();
    set_addr(16'h4000);
    checks++; if (rom_page !== 10'd2) begin errors++; $display("FAIL rmid_bank got %0d want 2", rom_page); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rmid_ram_en got %b want 0", ram_en); end
    checks++; if (dbg_rtc_armed !== 1'b0) begin errors++; $display("FAIL rmid_armed got %b want 0", dbg_rtc_armed); end
    tick();
    wr(16'h6000, 8'h01);
    wr(16'h4000, 8'h08);
`ifdef MBC_RTC_EN
    checks++; if (rtc_do !== 8'hC0) begin errors++; $display("FAIL rmid_no_latch got %h want c0", rtc_do); end
`else
    checks++; if (rtc_do !== 8'hFF) begin errors++; $display("FAIL rmid_rtc_do got %h want ff", rtc_do); end
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    test_reset();
    test_mbc1();
    test_mbc2();
    test_mbc3();
    test_mbc5();
    test_none();
`ifdef MBC_RTC_EN
    test_rtc_rollover();
    test_rtc_latch_seq();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
